fan_ctrl: RTL

FAN_CTRL -- requirements
Module: fan_ctrl

---
 rtl/fan_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fan_ctrl.sv
// fan_ctrl: CSR-programmed fan controller with spin-up, closed-loop duty regulation and stall detection.
module fan_ctrl #(
  parameter logic [4:0] BASE_ADDR = 5'h0,
  parameter int         SPINUP_S  = 2,
  parameter int         STALL_S   = 3,
  parameter int         STEP      = 8,
  parameter logic [7:0] DUTY_MIN  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       ce_1s,
  input  logic       tacho_valid,
  input  logic [9:0] tacho_cnt,
  output logic [7:0] duty,
  output logic       irq
);
  typedef enum logic [1:0] {OFF = 2'd0, SPINUP = 2'd1, REGULATE = 2'd2, STALL = 2'd3} state_t;
  state_t     state_q, state_d;
  logic       en_q, en_d, auto_q, auto_d, fie_q, fie_d, fault_q, fault_d;
  logic [7:0] target_q, target_d, dreg_q, dreg_d, duty_q, duty_d;
  logic [3:0] cnt_q, cnt_d, stall_q, stall_d;
  logic [4:0] off;
  logic       hit, ctrl_wr, tgt_wr, duty_wr, sts_wr, clr;
  logic [7:0] m, up, dn;
  logic [8:0] sum, diff;
  assign off     = csr_a - BASE_ADDR;
  assign hit     = off < 5'd4;
  assign ctrl_wr = csr_we && hit && off[1:0] == 2'd0;
  assign tgt_wr  = csr_we && hit && off[1:0] == 2'd1;
  assign duty_wr = csr_we && hit && off[1:0] == 2'd2;
  assign sts_wr  = csr_we && hit && off[1:0] == 2'd3;
  assign clr     = sts_wr && csr_di[0];
  assign m       = tacho_cnt[9:2];
  assign sum     = {1'b0, duty_q} + 9'(STEP);
  assign diff    = {1'b0, duty_q} - 9'(STEP);
  assign up      = sum[8] ? 8'hFF : sum[7:0];
  assign dn      = (diff[8] || diff[7:0] < DUTY_MIN) ? DUTY_MIN : diff[7:0];
  always_comb begin
    en_d     = ctrl_wr ? csr_di[0] : en_q;
    auto_d   = ctrl_wr ? csr_di[1] : auto_q;
    fie_d    = ctrl_wr ? csr_di[2] : fie_q;
    target_d = tgt_wr ? csr_di : target_q;
    dreg_d   = duty_wr ? csr_di : dreg_q;
    fault_d  = fault_q & ~clr;
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    duty_d   = duty_q;
    if (!en_d) begin
      state_d = OFF;
      cnt_d   = 4'd0;
      stall_d = 4'd0;
      duty_d  = 8'h00;
    end else begin
      case (state_q)
        OFF: begin
          state_d = SPINUP;
          cnt_d   = 4'(SPINUP_S);
          duty_d  = 8'hFF;
        end
        SPINUP: begin
          duty_d = 8'hFF;
          if (ce_1s) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = REGULATE;
              duty_d  = dreg_d;
            end
          end
        end
        REGULATE: begin
          if (!auto_q && duty_wr) duty_d = csr_di;
          if (tacho_valid) begin
            if (auto_q) duty_d = m < target_q ? up : m > target_q ? dn : duty_q;
            stall_d = tacho_cnt == 10'd0 ? stall_q + 4'd1 : 4'd0;
            // A detected stall overrides any simultaneous FAULT clear
            if (tacho_cnt == 10'd0 && stall_q + 4'd1 == 4'(STALL_S)) begin
              state_d = STALL;
              stall_d = 4'd0;
              fault_d = 1'b1;
              duty_d  = 8'hFF;
            end
          end
        end
        default: begin
          duty_d = 8'hFF;
          if (clr) begin
            state_d = SPINUP;
            cnt_d   = 4'(SPINUP_S);
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OFF;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      fie_q    <= 1'b0;
      fault_q  <= 1'b0;
      target_q <= 8'h80;
      dreg_q   <= 8'h80;
      duty_q   <= 8'h00;
      cnt_q    <= 4'd0;
      stall_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      fie_q    <= fie_d;
      fault_q  <= fault_d;
      target_q <= target_d;
      dreg_q   <= dreg_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
    end
  end
  assign duty   = duty_q;
  assign irq    = fault_q & fie_q;
  assign csr_do = !hit ? 8'h00 :
                  off[1:0] == 2'd0 ? {2'b00, state_q, 1'b0, fie_q, auto_q, en_q} :
                  off[1:0] == 2'd1 ? target_q :
                  off[1:0] == 2'd2 ? duty_q : {7'd0, fault_q};
endmodule
